// File: rtl/i2c_target_regfile.sv
// ============================================================================
// Module   : i2c_target_regfile
// Brief    : I2C target fronting a 2**PTR_WIDTH x DATA_WIDTH register file
//            through a byte-wide register pointer; open-drain SDA only.
// Revision : 1.0
// ============================================================================
`default_nettype none

module i2c_target_regfile #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 7,
    parameter logic [ADDR_WIDTH-1:0] ADDRESS    = 7'h10,
    parameter int                    PTR_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_out,
    output logic                  busy,
    output logic                  reg_wr_pulse,
    output logic [PTR_WIDTH-1:0]  reg_wr_addr,
    output logic [DATA_WIDTH-1:0] reg_wr_data,
    input  logic [PTR_WIDTH-1:0]  local_addr,
    output logic [DATA_WIDTH-1:0] local_rdata
);

    localparam int                NREG     = 2 ** PTR_WIDTH;
    localparam int                CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0]  ALL_BITS = CNT_W'(DATA_WIDTH);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ADDR      = 4'd1,
        S_ADDR_ACK  = 4'd2,
        S_PTR       = 4'd3,
        S_PTR_ACK   = 4'd4,
        S_WDATA     = 4'd5,
        S_WDATA_ACK = 4'd6,
        S_RDATA     = 4'd7,
        S_RACK      = 4'd8
    } state_t;

    state_t                state_q, state_d;
    logic                  scl_s1_q, scl_s2_q, scl_dly_q;
    logic                  sda_s1_q, sda_s2_q, sda_dly_q;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [PTR_WIDTH-1:0]  ptr_q, ptr_d;
    logic                  sda_q, sda_d;
    logic                  busy_q, busy_d;
    logic                  ack_on_q, ack_on_d;
    logic                  rw_q, rw_d;
    logic                  wr_pulse_q, wr_pulse_d;
    logic [PTR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  we;
    logic [DATA_WIDTH-1:0] regs_q [NREG];

    logic                  scl_rise, scl_fall, start_det, stop_det;
    logic [DATA_WIDTH-1:0] byte_in, rd_word;

    assign scl_rise  = scl_s2_q & ~scl_dly_q;
    assign scl_fall  = ~scl_s2_q & scl_dly_q;
    assign start_det = scl_s2_q & sda_dly_q & ~sda_s2_q;
    assign stop_det  = scl_s2_q & ~sda_dly_q & sda_s2_q;
    assign byte_in   = {shift_q[DATA_WIDTH-2:0], sda_s2_q};
    assign rd_word   = regs_q[ptr_q];

    assign sda_out      = sda_q;
    assign busy         = busy_q;
    assign reg_wr_pulse = wr_pulse_q;
    assign reg_wr_addr  = wr_addr_q;
    assign reg_wr_data  = wr_data_q;
    assign local_rdata  = regs_q[local_addr];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        sda_d      = sda_q;
        busy_d     = busy_q;
        ack_on_d   = ack_on_q;
        rw_d       = rw_q;
        wr_pulse_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        we         = 1'b0;

        if (stop_det) begin
            state_d  = S_IDLE;
            busy_d   = 1'b0;
            sda_d    = 1'b1;
            ack_on_d = 1'b0;
        end else if (start_det) begin
            state_d  = S_ADDR;
            cnt_d    = '0;
            busy_d   = 1'b1;
            sda_d    = 1'b1;
            ack_on_d = 1'b0;
        end else begin
            case (state_q)
                S_ADDR, S_PTR, S_WDATA: begin
                    if (scl_rise) begin
                        shift_d = byte_in;
                        cnt_d   = cnt_q + 1'b1;
                        if (cnt_q == LAST_BIT) begin
                            cnt_d = '0;
                            if (state_q == S_ADDR) begin
                                rw_d    = byte_in[0];
                                state_d = (byte_in[ADDR_WIDTH:1] == ADDRESS) ? S_ADDR_ACK : S_IDLE;
                            end else if (state_q == S_PTR) begin
                                ptr_d   = byte_in[PTR_WIDTH-1:0];
                                state_d = S_PTR_ACK;
                            end else begin
                                we         = 1'b1;
                                wr_pulse_d = 1'b1;
                                wr_addr_d  = ptr_q;
                                wr_data_d  = byte_in;
                                ptr_d      = ptr_q + 1'b1;
                                state_d    = S_WDATA_ACK;
                            end
                        end
                    end
                end
                // First falling edge asserts ACK, second one ends the ACK slot.
                S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!ack_on_q) begin
                            sda_d    = 1'b0;
                            ack_on_d = 1'b1;
                        end else begin
                            ack_on_d = 1'b0;
                            sda_d    = 1'b1;
                            if (state_q == S_ADDR_ACK && rw_q) begin
                                shift_d = {rd_word[DATA_WIDTH-2:0], 1'b0};
                                sda_d   = rd_word[DATA_WIDTH-1];
                                ptr_d   = ptr_q + 1'b1;
                                cnt_d   = CNT_W'(1);
                                state_d = S_RDATA;
                            end else if (state_q == S_ADDR_ACK) begin
                                state_d = S_PTR;
                            end else begin
                                state_d = S_WDATA;
                            end
                        end
                    end
                end
                S_RDATA: begin
                    if (scl_fall) begin
                        if (cnt_q == ALL_BITS) begin
                            sda_d    = 1'b1;
                            ack_on_d = 1'b0;
                            state_d  = S_RACK;
                        end else begin
                            sda_d   = shift_q[DATA_WIDTH-1];
                            shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
                            cnt_d   = cnt_q + 1'b1;
                        end
                    end
                end
                S_RACK: begin
                    if (scl_rise) begin
                        if (sda_s2_q) begin
                            state_d = S_IDLE;
                        end else begin
                            ack_on_d = 1'b1;
                        end
                    end else if (scl_fall && ack_on_q) begin
                        ack_on_d = 1'b0;
                        shift_d  = {rd_word[DATA_WIDTH-2:0], 1'b0};
                        sda_d    = rd_word[DATA_WIDTH-1];
                        ptr_d    = ptr_q + 1'b1;
                        cnt_d    = CNT_W'(1);
                        state_d  = S_RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_s1_q   <= 1'b1;
            scl_s2_q   <= 1'b1;
            scl_dly_q  <= 1'b1;
            sda_s1_q   <= 1'b1;
            sda_s2_q   <= 1'b1;
            sda_dly_q  <= 1'b1;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            ptr_q      <= '0;
            sda_q      <= 1'b1;
            busy_q     <= 1'b0;
            ack_on_q   <= 1'b0;
            rw_q       <= 1'b0;
            wr_pulse_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            scl_s1_q   <= scl_in;
            scl_s2_q   <= scl_s1_q;
            scl_dly_q  <= scl_s2_q;
            sda_s1_q   <= sda_in;
            sda_s2_q   <= sda_s1_q;
            sda_dly_q  <= sda_s2_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            sda_q      <= sda_d;
            busy_q     <= busy_d;
            ack_on_q   <= ack_on_d;
            rw_q       <= rw_d;
            wr_pulse_q <= wr_pulse_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we) begin
            regs_q[ptr_q] <= wr_data_d;
        end
    end

endmodule

`default_nettype wire

// File: doc/i2c_target_regfile.md
Name: i2c_target_regfile

Overview:
- I2C target (responder) that answers a bus initiator on SCL/SDA.
- Holds an internal 2**PTR_WIDTH x DATA_WIDTH register file, accessed over the bus through a byte-wide register pointer.
- Oversamples the bus with the local clock: 2-FF synchronizers plus edge detection. Drives SDA open-drain only.
- Sits beside the existing controller path as the bus-side end: it acknowledges, accepts written bytes and returns read bytes.

Parameters:
- DATA_WIDTH, 8: register and I2C data byte width.
- ADDRESS, 7'h10: this target's 7-bit bus address.
- ADDR_WIDTH, 7: bus address width.
- PTR_WIDTH, 4: register pointer width. Register count is 2**PTR_WIDTH.

Ports:
- clk  in  1  local clock; at least 10x the SCL rate.
- rst  in  1  synchronous, active-high reset.
- scl_in  in  1  raw SCL level from the bus.
- sda_in  in  1  raw SDA level from the bus.
- sda_out  out  1  0 pulls SDA low, 1 releases it. ANDed onto the bus at top level.
- busy  out  1  high from START detection to STOP detection.
- reg_wr_pulse  out  1  one-cycle strobe per register written over the bus.
- reg_wr_addr  out  PTR_WIDTH  register index of the strobed write.
- reg_wr_data  out  DATA_WIDTH  data of the strobed write.
- local_addr  in  PTR_WIDTH  local-side read index.
- local_rdata  out  DATA_WIDTH  combinational regfile[local_addr].

Behaviour:
- Reset values:
  - sda_out=1, busy=0, reg_wr_pulse=0, reg_wr_addr=0, reg_wr_data=0.
  - All registers=0, pointer=0, state=IDLE.
  - Reset mid-transfer releases SDA on the next clk.
- Input path:
  - scl and sda each pass two sync flops, then a delay flop.
  - scl_rise / scl_fall are edges of the synced SCL.
  - START: synced SDA falls while synced SCL=1. STOP: synced SDA rises while synced SCL=1.
  - Detection latency is 3 clk after the pin change.
- Bit timing:
  - Sample SDA on scl_rise.
  - Change sda_out only in the cycle after scl_fall.
- Priority: STOP, then START, then SCL edge handling.
  - STOP in any state: go to IDLE, busy=0, release SDA.
  - START in any state (including repeated START): go to ADDR, clear bit counter, busy=1, release SDA.
- States:
  - IDLE: ignore SCL edges.
  - ADDR: shift in 8 bits MSB first (7 address bits + R/W).
    - Match with R/W=0: ADDR_ACK, then PTR.
    - Match with R/W=1: ADDR_ACK, then RDATA.
    - Mismatch, including general call 0x00: IDLE; SDA stays released (NACK).
  - ADDR_ACK / PTR_ACK / WDATA_ACK: drive sda_out=0 at the scl_fall ending the 8th bit; release at the next scl_fall.
  - PTR: shift 8 bits. pointer := byte[PTR_WIDTH-1:0]. Go to PTR_ACK, then WDATA.
  - WDATA: on the scl_rise of bit 8:
    - Write regfile[pointer]; pulse reg_wr_pulse with reg_wr_addr=pointer and the data.
    - pointer increments modulo 2**PTR_WIDTH (wraps max to 0).
    - Then WDATA_ACK, then WDATA.
  - RDATA entry: at the scl_fall ending ADDR_ACK or RACK, load shifter from regfile[pointer], increment pointer (same wrap), drive the MSB.
  - RDATA bit shifting: each later scl_fall drives the next bit; after bit 8's scl_fall, release SDA and go to RACK.
  - RACK: sample SDA on scl_rise. 0 = ACK: load next byte as above. 1 = NACK: go to IDLE with SDA released.
- Pointer persists across transactions; only reset clears it.
- A bus write and a local read of the same index in the same cycle: local_rdata shows the old value that cycle.
- No clock stretching; sda_out never changes while synced SCL=1, except on the release caused by START/STOP.

Test Plan:
- Write: S, 0x20(W), ptr 0x03, data 0xA5, 0x5A, P -> ACK on all 4 bytes; reg[3]=0xA5, reg[4]=0x5A; two reg_wr_pulse with addr 3 then 4; busy low after P.
- Read with repeated START: S, 0x20, ptr 0x03, Sr, 0x21, initiator ACK then NACK, P -> bytes 0xA5, 0x5A on SDA MSB first; pointer ends at 5.
- Wrong address: S, 0x22(W), data, P -> SDA never pulled low; no reg_wr_pulse; registers unchanged.
- Pointer wrap: ptr 0x0F, write 0x11, 0x22 -> reg[15]=0x11, reg[0]=0x22; local_addr=0 gives local_rdata=0x22.
- Mid-byte STOP and reset: STOP after 4 data bits -> IDLE, no write; rst asserted while driving ACK -> sda_out=1 next clk, all registers 0.
